// File: rtl/cvp14_core.sv
// cvp14_core: multicycle 16-bit core with 8 registers, a 16-bit PC and a
// single-ported memory bus (Addr/RD/WR/DataOut out, DataIn back).
//
// Bus handshake: RD or WR is high for exactly one cycle per access. Addr,
// RD, WR and DataOut are registers, all valid during that cycle. For a read,
// the memory returns DataIn in the following cycle, and the core samples it
// at the end of that cycle. For a write, the memory takes DataOut at Addr
// during the WR cycle. RD and WR are never high together.
//
// Bus registers are loaded with the values for the state being entered, so
// a FETCH cycle already shows Addr=PC, RD=1. Reset leaves the core in FETCH
// with RD=0. That first FETCH cycle only issues the read, so the first real
// fetch cycle is the one after the first clock edge out of reset.
module cvp14_core #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic [15:0] DataIn,
    output logic [15:0] Addr,
    output logic        RD,
    output logic        WR,
    output logic        V,
    output logic [15:0] DataOut,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_FWAIT = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_MWAIT = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_LLB  = 4'h6;
    localparam logic [3:0] OP_LHB  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BEQZ = 4'hA;
    localparam logic [3:0] OP_JR   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hC;

    state_t      state, state_nx;
    logic [15:0] pc, ir;
    logic [15:0] rf [8];

    logic [3:0]  op;
    logic [2:0]  f_rd, f_rs, f_rt;
    logic [15:0] rd_val, rs_val, rt_val;
    logic [15:0] ea, pc_exec;
    logic [15:0] alu_res;
    logic        alu_we, alu_v;
    logic [15:0] addr_nx, dout_nx;
    logic        rd_nx, wr_nx;

    // Instruction fields and operand reads. R0 is never written, so it reads 0.
    assign op      = ir[15:12];
    assign f_rd    = ir[11:9];
    assign f_rs    = ir[8:6];
    assign f_rt    = ir[5:3];
    assign rd_val  = rf[f_rd];
    assign rs_val  = rf[f_rs];
    assign rt_val  = rf[f_rt];
    assign ea      = rs_val + {{10{ir[5]}}, ir[5:0]};
    assign dbg_state = state;

    // ALU results and register-write enable for ops that finish in EXEC.
    always_comb begin
        alu_res = 16'h0000;
        alu_we  = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = rs_val + rt_val;
                alu_we  = 1'b1;
                alu_v   = (rs_val[15] == rt_val[15]) && (alu_res[15] != rs_val[15]);
            end
            OP_SUB: begin
                alu_res = rs_val - rt_val;
                alu_we  = 1'b1;
                alu_v   = (rs_val[15] != rt_val[15]) && (alu_res[15] != rs_val[15]);
            end
            OP_AND: begin alu_res = rs_val & rt_val;           alu_we = 1'b1; end
            OP_OR:  begin alu_res = rs_val | rt_val;           alu_we = 1'b1; end
            OP_XOR: begin alu_res = rs_val ^ rt_val;           alu_we = 1'b1; end
            OP_SLL: begin alu_res = rs_val << ir[3:0];         alu_we = 1'b1; end
            OP_LLB: begin alu_res = {rd_val[15:8], ir[7:0]};   alu_we = 1'b1; end
            OP_LHB: begin alu_res = {ir[7:0], rd_val[7:0]};    alu_we = 1'b1; end
            default: ;
        endcase
    end

    // PC after EXEC. It is already incremented, so a zero branch offset falls through.
    always_comb begin
        pc_exec = pc;
        if (op == OP_BEQZ && rd_val == 16'h0000)
            pc_exec = pc + {{7{ir[8]}}, ir[8:0]};
        else if (op == OP_JR)
            pc_exec = rs_val;
    end

    // Next state plus next bus values for the state being entered.
    always_comb begin
        state_nx = state;
        addr_nx  = Addr;
        dout_nx  = DataOut;
        rd_nx    = 1'b0;
        wr_nx    = 1'b0;
        case (state)
            S_FETCH: begin
                if (RD) begin
                    state_nx = S_FWAIT;
                end else begin
                    // only reached straight out of reset: issue the fetch now
                    addr_nx = pc;
                    rd_nx   = 1'b1;
                end
            end
            S_FWAIT: state_nx = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_LD: begin
                        state_nx = S_MEM;
                        addr_nx  = ea;
                        rd_nx    = 1'b1;
                    end
                    OP_ST: begin
                        state_nx = S_MEM;
                        addr_nx  = ea;
                        wr_nx    = 1'b1;
                        dout_nx  = rd_val;
                    end
                    OP_HALT: begin
                        state_nx = S_HALT;
                        addr_nx  = 16'hFFFF;
                    end
                    default: begin
                        state_nx = S_FETCH;
                        addr_nx  = pc_exec;
                        rd_nx    = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (op == OP_ST) begin
                    state_nx = S_FETCH;
                    addr_nx  = pc;
                    rd_nx    = 1'b1;
                end else begin
                    state_nx = S_MWAIT;
                end
            end
            S_MWAIT: begin
                state_nx = S_FETCH;
                addr_nx  = pc;
                rd_nx    = 1'b1;
            end
            S_HALT: addr_nx = 16'hFFFF;
            default: state_nx = S_FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) state <= S_FETCH;
        else        state <= state_nx;
    end

    // Datapath and bus registers. Reset discards any instruction in flight.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            pc      <= RESET_PC;
            ir      <= 16'h0000;
            V       <= 1'b0;
            Addr    <= 16'h0000;
            RD      <= 1'b0;
            WR      <= 1'b0;
            DataOut <= 16'h0000;
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
        end else begin
            Addr    <= addr_nx;
            RD      <= rd_nx;
            WR      <= wr_nx;
            DataOut <= dout_nx;
            if (state == S_FWAIT) begin
                ir <= DataIn;
                pc <= pc + 16'd1;
            end
            if (state == S_EXEC) begin
                pc <= pc_exec;
                if (alu_we && f_rd != 3'd0) rf[f_rd] <= alu_res;
                if (op == OP_ADD || op == OP_SUB) V <= alu_v;
            end
            if (state == S_MWAIT && f_rd != 3'd0) rf[f_rd] <= DataIn;
        end
    end

endmodule

// File: tb/tb_cvp14_core.sv
// Bench for cvp14_core: bus-level memory model, instruction-set reference
// model and directed plus random programs.
module tb_cvp14_core;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        Clk1 = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] DataIn = 16'h0000;
    logic [15:0] Addr, DataOut;
    logic        RD, WR, V;
    logic [2:0]  dbg_state;

    cvp14_core #(.RESET_PC(RESET_PC)) dut (
        .Clk1(Clk1), .Reset(Reset), .DataIn(DataIn), .Addr(Addr),
        .RD(RD), .WR(WR), .V(V), .DataOut(DataOut), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 Clk1 = ~Clk1;

    logic [15:0] mem  [65536];
    logic [15:0] mmem [65536];
    logic [15:0] act_r[$];
    int          act_rc[$];
    logic [31:0] act_w[$];
    logic [15:0] exp_r[$];
    logic [31:0] exp_q[$];
    int          exp_cycles;
    logic        exp_v;
    int          n_assert = 0;
    int          n_fail = 0;
    int          mcyc = 0;
    int          run_cycles;
    bit          halted;

    // memory responder and bus monitor, sampled mid-cycle
    always @(negedge Clk1) begin
        mcyc++;
        if (RD) begin
            act_r.push_back(Addr);
            act_rc.push_back(mcyc);
            DataIn = mem[Addr];
        end
        if (WR) begin
            act_w.push_back({Addr, DataOut});
            mem[Addr] = DataOut;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ins(input int op, input int d, input int s, input int lo6);
        logic [3:0] o; logic [2:0] a, b; logic [5:0] l;
        o = op[3:0]; a = d[2:0]; b = s[2:0]; l = lo6[5:0];
        return {o, a, b, l};
    endfunction

    function automatic logic [15:0] i8(input int op, input int d, input int imm);
        logic [3:0] o; logic [2:0] a; logic [7:0] l;
        o = op[3:0]; a = d[2:0]; l = imm[7:0];
        return {o, a, 1'b0, l};
    endfunction

    function automatic logic [15:0] b9(input int d, input int off);
        logic [2:0] a; logic [8:0] l;
        a = d[2:0]; l = off[8:0];
        return {4'hA, a, l};
    endfunction

    function automatic logic [31:0] w_at(input int i);
        if (i < act_w.size()) return act_w[i];
        return 'x;
    endfunction

    function automatic logic [31:0] r_at(input int i);
        if (i < act_r.size()) return {16'h0000, act_r[i]};
        return 'x;
    endfunction

    function automatic int rc_at(input int i);
        if (i < act_rc.size()) return act_rc[i];
        return -1000;
    endfunction

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = 16'h0000;
    endtask

    // instruction-set reference model: expected reads, writes, cycles, V
    task automatic model_run();
        logic [15:0] r [8];
        logic [15:0] pc, ir, a, b, ea, nv;
        logic [3:0]  op;
        logic [2:0]  d;
        int          res, steps;
        bit          done, we;
        mmem = mem;
        exp_r.delete(); exp_q.delete();
        exp_cycles = 0; exp_v = 1'b0;
        foreach (r[i]) r[i] = 16'h0000;
        pc = RESET_PC; steps = 0; done = 0;
        while (!done && steps < 2000) begin
            steps++;
            ir = mmem[pc];
            exp_r.push_back(pc);
            pc = pc + 16'd1;
            op = ir[15:12]; d = ir[11:9];
            a = r[ir[8:6]]; b = r[ir[5:3]];
            ea = 16'(int'(a) + int'($signed(ir[5:0])));
            exp_cycles += 3;
            we = 1'b0; nv = 16'h0000;
            case (op)
                4'h0: begin
                    res = int'($signed(a)) + int'($signed(b));
                    exp_v = (res > 32767 || res < -32768); nv = 16'(res); we = 1'b1;
                end
                4'h1: begin
                    res = int'($signed(a)) - int'($signed(b));
                    exp_v = (res > 32767 || res < -32768); nv = 16'(res); we = 1'b1;
                end
                4'h2: begin nv = a & b; we = 1'b1; end
                4'h3: begin nv = a | b; we = 1'b1; end
                4'h4: begin nv = a ^ b; we = 1'b1; end
                4'h5: begin nv = a << ir[3:0]; we = 1'b1; end
                4'h6: begin nv = {r[d][15:8], ir[7:0]}; we = 1'b1; end
                4'h7: begin nv = {ir[7:0], r[d][7:0]}; we = 1'b1; end
                4'h8: begin
                    exp_cycles += 2; exp_r.push_back(ea); nv = mmem[ea]; we = 1'b1;
                end
                4'h9: begin
                    exp_cycles += 1; mmem[ea] = r[d]; exp_q.push_back({ea, r[d]});
                end
                4'hA: if (r[d] == 16'h0000) pc = 16'(int'(pc) + int'($signed(ir[8:0])));
                4'hB: pc = a;
                4'hC: done = 1;
                default: ;
            endcase
            if (we && d != 3'd0) r[d] = nv;
        end
    endtask

    // driver: reset, release, run until the halt address appears
    task automatic run_prog(input int budget);
        Reset = 1'b0;
        @(negedge Clk1);
        chk("reset_outputs", {Addr, RD, WR, V, DataOut}, 32'h0);
        act_r.delete(); act_rc.delete(); act_w.delete();
        Reset = 1'b1;
        @(negedge Clk1);
        chk("first_fetch", {Addr, RD}, {RESET_PC, 1'b1});
        run_cycles = 1; halted = 0;
        while (!halted && run_cycles < budget) begin
            @(negedge Clk1);
            if (Addr == 16'hFFFF && !RD && !WR) halted = 1;
            else run_cycles++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
        repeat (4) @(negedge Clk1);
        chk("halt_hold", {Addr, RD, WR}, {16'hFFFF, 2'b00});
    endtask

    // scoreboard: compare the run against the reference model
    task automatic run_and_check(input string name, input int budget);
        model_run();
        run_prog(budget);
        chk({name, " cycles"}, run_cycles, exp_cycles);
        chk({name, " n_reads"}, act_r.size(), exp_r.size());
        foreach (exp_r[i]) chk({name, " read_addr"}, r_at(i), {16'h0000, exp_r[i]});
        chk({name, " n_writes"}, act_w.size(), exp_q.size());
        foreach (exp_q[i]) chk({name, " write"}, w_at(i), exp_q[i]);
        chk({name, " v_flag"}, 32'(V), 32'(exp_v));
    endtask

    initial begin
        int k;
        bit seen;
        int opsel [12];
        opsel = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 13};
        clear_mem();
        repeat (2) @(negedge Clk1);

        // LLB/LHB build 0x1234; fetches 3 cycles apart
        clear_mem();
        mem[0] = i8(6, 1, 8'h34); mem[1] = i8(7, 1, 8'h12);
        mem[2] = ins(9, 1, 0, 5); mem[3] = ins(12, 0, 0, 0);
        run_and_check("llb_lhb", 200);
        chk("llb_lhb store", w_at(0), {16'h0005, 16'h1234});
        chk("fetch_gap", rc_at(1) - rc_at(0), 3);

        // ADD overflow sets V
        clear_mem();
        mem[0] = i8(6, 1, 8'hFF); mem[1] = i8(7, 1, 8'h7F); mem[2] = i8(6, 2, 8'h01);
        mem[3] = ins(0, 3, 1, 2 << 3); mem[4] = ins(9, 3, 0, 0); mem[5] = ins(12, 0, 0, 0);
        run_and_check("add_ovf", 200);
        chk("add_ovf r3", w_at(0), {16'h0000, 16'h8000});
        chk("add_ovf v", 32'(V), 32'd1);

        // SUB of equal values clears V
        mem[5] = ins(1, 4, 3, 3 << 3); mem[6] = ins(9, 4, 0, 1); mem[7] = ins(12, 0, 0, 0);
        run_and_check("sub_zero", 200);
        chk("sub_zero r4", w_at(1), {16'h0001, 16'h0000});
        chk("sub_zero v", 32'(V), 32'd0);

        // ST then LD through base+offset, LD latency 5
        clear_mem();
        mem[0] = i8(6, 1, 8'h00); mem[1] = i8(7, 1, 8'h01);
        mem[2] = ins(9, 1, 1, 2); mem[3] = ins(8, 5, 1, 2);
        mem[4] = ins(9, 5, 0, 31); mem[5] = ins(12, 0, 0, 0);
        run_and_check("st_ld", 200);
        chk("st write", w_at(0), {16'h0102, 16'h0100});
        chk("ld data", w_at(1), {16'h001F, 16'h0100});
        chk("ld read_at", rc_at(4) - rc_at(3), 3);
        chk("ld latency", rc_at(5) - rc_at(3), 5);

        // BEQZ at 0x10, taken and not taken; JR to HALT at 0x20
        for (int v = 0; v < 2; v++) begin
            clear_mem();
            mem[0] = i8(6, 2, v); mem[1] = b9(0, 14);
            mem[16'h10] = b9(2, 3); mem[16'h11] = ins(12, 0, 0, 0);
            mem[16'h14] = i8(6, 3, 8'h20); mem[16'h15] = ins(11, 0, 3, 0);
            mem[16'h20] = ins(12, 0, 0, 0);
            run_and_check("beqz", 200);
            chk("beqz target", r_at(3), (v == 0) ? 32'h14 : 32'h11);
        end

        // Reset during the LD wait cycle aborts it
        clear_mem();
        mem[0] = i8(6, 1, 8'hFF); mem[1] = i8(7, 1, 8'h7F);
        mem[2] = ins(0, 2, 1, 1 << 3); mem[3] = ins(8, 5, 0, 31);
        mem[4] = ins(12, 0, 0, 0); mem[31] = 16'hBEEF;
        Reset = 1'b0; @(negedge Clk1); Reset = 1'b1;
        seen = 0; k = 0;
        while (!seen && k < 60) begin
            @(negedge Clk1); k++;
            if (RD && Addr == 16'h001F) seen = 1;
        end
        chk("mid_ld seen", 32'(seen), 32'd1);
        chk("mid_ld v_before", 32'(V), 32'd1);
        @(negedge Clk1);
        Reset = 1'b0;
        #1;
        chk("mid_ld reset_outputs", {Addr, RD, WR, V, DataOut}, 32'h0);
        clear_mem();
        mem[0] = ins(9, 5, 0, 9); mem[1] = ins(12, 0, 0, 0);
        run_and_check("after_abort", 200);
        chk("after_abort r5", w_at(0), {16'h0009, 16'h0000});

        // random programs against the reference model
        for (int t = 0; t < 4; t++) begin
            int p, o;
            clear_mem();
            for (int i = 16'h3FE0; i <= 16'h401F; i++) mem[i] = 16'($urandom);
            mem[0] = i8(6, 7, 8'h00); mem[1] = i8(7, 7, 8'h40);
            p = 2;
            for (int n = 0; n < 40; n++) begin
                o = opsel[$urandom_range(0, 11)];
                if (o == 8)       mem[p] = ins(8, $urandom_range(0, 6), 7, $urandom_range(0, 63));
                else if (o == 9)  mem[p] = ins(9, $urandom_range(0, 7), 7, $urandom_range(0, 63));
                else if (o == 10) mem[p] = b9($urandom_range(0, 7), $urandom_range(0, 3));
                else mem[p] = ins(o, $urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 63));
                p++;
            end
            for (int n = 0; n < 4; n++) begin mem[p] = 16'hD000; p++; end
            for (int n = 0; n < 8; n++) begin mem[p] = ins(9, n, 7, 24 + n); p++; end
            mem[p] = ins(12, 0, 0, 0);
            run_and_check("random", 1000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cvp14_core.md
CVP14_CORE -- requirements
Module: cvp14

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: instruction address fetched first after reset.
REQ-002 SHALL have port Clk1  input  1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port DataIn  input  16: read data from memory, valid in the cycle after a read request.
REQ-005 SHALL have port Addr  output  16: registered memory address; holds its last value when no access is made.
REQ-006 SHALL have port RD  output  1: read request for the current cycle.
REQ-007 SHALL have port WR  output  1: write request for the current cycle; never high together with RD.
REQ-008 SHALL have port V  output  1: signed-overflow flag from the most recent ADD/SUB.
REQ-009 SHALL have port DataOut  output  16: write data, valid whenever WR=1.

Function
REQ-010 SHALL be a multicycle 16-bit core with 8 registers R0-R7 and a 16-bit PC; R0 SHALL read as 0 and ignore writes.
REQ-011 Instruction format: op=[15:12], rd=[11:9], rs=[8:6], rt=[5:3], imm4=[3:0], imm6=[5:0], imm8=[7:0], imm9=[8:0].
REQ-012 Opcodes: 0 ADD rd=rs+rt; 1 SUB rd=rs-rt; 2 AND; 3 OR; 4 XOR; 5 SLL rd=rs<<imm4; 6 LLB rd={rd[15:8],imm8}; 7 LHB rd={imm8,rd[7:0]}.
REQ-013 Opcodes: 8 LD rd=Mem[rs+sext(imm6)]; 9 ST Mem[rs+sext(imm6)]=rd; A BEQZ if rd==0 then PC=PC+1+sext(imm9); B JR PC=rs; C HALT; D-F NOP.
REQ-014 All arithmetic SHALL be 16-bit modulo 2^16; address arithmetic wraps from 0xFFFF to 0x0000.
REQ-015 V SHALL update only on ADD/SUB, set to 1 on two's-complement signed overflow, else 0.
REQ-016 States: FETCH, FWAIT, EXEC, MEM, MWAIT, HALT.
REQ-017 FETCH: Addr=PC, RD=1; next state FWAIT.
REQ-018 FWAIT: capture DataIn into IR at end of cycle; PC=PC+1; next state EXEC.
REQ-019 EXEC: ALU/LLB/LHB write rd; branch/JR update PC; next state FETCH. LD/ST go to MEM. HALT goes to HALT.
REQ-020 MEM: Addr=effective address; LD drives RD=1 and goes to MWAIT; ST drives WR=1, DataOut=rd and goes to FETCH.
REQ-021 MWAIT: write DataIn into rd at end of cycle; next state FETCH.
REQ-022 Latency: ALU/branch/JR/NOP 3 cycles, ST 4 cycles, LD 5 cycles.
REQ-023 HALT: Addr=16'hFFFF, RD=0, WR=0 from the cycle after EXEC of HALT, held until reset; the environment treats Addr=0xFFFF as end of program.
REQ-024 BEQZ with taken offset SHALL use the already-incremented PC, so offset 0 falls through to PC+1.
REQ-025 LD with rd=R0 SHALL perform the memory read and discard the data.

Reset
REQ-026 While Reset=0, asynchronously: state=FETCH, PC=RESET_PC, R0-R7=0, IR=0, V=0, RD=0, WR=0, Addr=0, DataOut=0.
REQ-027 The first fetch (Addr=RESET_PC, RD=1) SHALL occur in the first cycle after Reset deasserts.
REQ-028 Reset asserted mid-instruction SHALL abort it; no partial register or memory write is committed.

Verification
REQ-029 Reset, then LLB R1,0x34 and LHB R1,0x12 -> R1=0x1234; RD pulses at Addr 0x0000 and 0x0001, 3 cycles apart.
REQ-030 R1=0x7FFF, R2=0x0001, ADD R3,R1,R2 -> R3=0x8000, V=1; then SUB R4,R3,R3 -> R4=0, V=0.
REQ-031 R1=0x0100, ST R1,R1,+2 -> WR=1, Addr=0x0102, DataOut=0x0100; then LD R5,R1,+2 -> R5=0x0100, 5 cycles.
REQ-032 R2=0, BEQZ R2,+3 at PC 0x0010 -> next fetch Addr=0x0014; with R2=1 -> next fetch Addr=0x0011.
REQ-033 HALT at 0x0020 -> Addr=0xFFFF, RD=WR=0 held; assert Reset=0 mid-LD -> destination register unchanged, next fetch at RESET_PC.
